boxcar_decimator: RTL and testbench

- Upstream feeder for the fixed/variable delay stage: decimates a full-rate signed sample stream by a runtime power-of-two ratio N = 2^log2_ratio.
- Emits the rounded boxcar mean of each block of N samples plus a one-cycle clock-enable strobe.
- ce_out/sig_out connect directly to the delay stage's ce_in/sig_in, so downstream control blocks run at the reduced rate.

---
 rtl/boxcar_decimator.sv | 78 +++++++
 tb/tb_boxcar_decimator.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/boxcar_decimator.sv
// Power-of-two boxcar decimator: averages each block of N = 2^log2_ratio samples
// with round-half-up and emits the mean with a one-cycle strobe.
module boxcar_decimator #(
    parameter int DW = 16,
    parameter int RW = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 ce_in,
    input  logic signed [DW-1:0] sig_in,
    input  logic [RW-1:0]        log2_ratio,
    output logic                 ce_out,
    output logic signed [DW-1:0] sig_out
);

    localparam int ACCW = DW + 2**RW - 1;
    localparam int CW   = 2**RW - 1;

    logic signed [ACCW-1:0] acc_q, acc_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic [RW-1:0]          k_act_q, k_act_d;
    logic                   ce_out_q, ce_out_d;
    logic signed [DW-1:0]   sig_out_q, sig_out_d;

    logic [RW-1:0]          k_eff;
    logic [CW-1:0]          last_idx;
    logic signed [ACCW-1:0] acc_sum;
    logic signed [ACCW-1:0] round_bias;
    logic signed [ACCW-1:0] rounded;

    always_comb begin
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        k_act_d   = k_act_q;
        ce_out_d  = 1'b0;
        sig_out_d = sig_out_q;

        // The first sample of a block takes the live ratio; later samples use the latched one.
        k_eff      = (cnt_q == '0) ? log2_ratio : k_act_q;
        last_idx   = ~({CW{1'b1}} << k_eff);
        acc_sum    = ((cnt_q == '0) ? '0 : acc_q)
                     + {{(ACCW-DW){sig_in[DW-1]}}, sig_in};
        round_bias = (ACCW'(1) << k_eff) >>> 1;
        rounded    = acc_sum + round_bias;

        if (ce_in) begin
            k_act_d = k_eff;
            acc_d   = acc_sum;
            if (cnt_q == last_idx) begin
                cnt_d     = '0;
                ce_out_d  = 1'b1;
                sig_out_d = DW'(rounded >>> k_eff);
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q     <= '0;
            cnt_q     <= '0;
            k_act_q   <= '0;
            ce_out_q  <= 1'b0;
            sig_out_q <= '0;
        end else begin
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            k_act_q   <= k_act_d;
            ce_out_q  <= ce_out_d;
            sig_out_q <= sig_out_d;
        end
    end

    assign ce_out  = ce_out_q;
    assign sig_out = sig_out_q;

endmodule

// File: tb/tb_boxcar_decimator.sv
// Directed self-checking bench for boxcar_decimator.
module tb_boxcar_decimator;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               ce_in = 1'b0;
    logic signed [15:0] sig_in = '0;
    logic [2:0]         log2_ratio = '0;
    logic               ce_out;
    logic signed [15:0] sig_out;

    int n_checks = 0;
    int n_fail   = 0;

    boxcar_decimator #(.DW(16), .RW(3)) dut (
        .clk        (clk),
        .rst        (rst),
        .ce_in      (ce_in),
        .sig_in     (sig_in),
        .log2_ratio (log2_ratio),
        .ce_out     (ce_out),
        .sig_out    (sig_out)
    );

    always #5 clk = ~clk;

    // Apply inputs, clock once, then look at the registered outputs 1 ns later.
    task automatic drive(input logic ce, input logic signed [15:0] s);
        ce_in  = ce;
        sig_in = s;
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        drive(1'b0, 16'sd0);
        drive(1'b0, 16'sd0);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        log2_ratio = 3'd2;
        drive(1'b1, 16'sd77);
        n_checks++;
        if (ce_out !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_ce_out: got %b expected 0", ce_out);
        end
        n_checks++;
        if (sig_out !== 16'sd0) begin
            n_fail++;
            $display("FAIL reset_sig_out: got %0d expected 0", sig_out);
        end
        rst = 1'b0;
    endtask

    task automatic test_ramp();
        logic signed [15:0] exp_sig;
        logic               exp_ce;
        apply_reset();
        log2_ratio = 3'd2;
        exp_sig = 16'sd0;
        for (int i = 0; i < 12; i++) begin
            drive(1'b1, 16'(i));
            exp_ce = (i % 4 == 3);
            if (exp_ce) exp_sig = 16'(4 * (i / 4) + 2);
            n_checks++;
            if (ce_out !== exp_ce) begin
                n_fail++;
                $display("FAIL ramp_ce i=%0d: got %b expected %b", i, ce_out, exp_ce);
            end
            n_checks++;
            if (sig_out !== exp_sig) begin
                n_fail++;
                $display("FAIL ramp_sig i=%0d: got %0d expected %0d", i, sig_out, exp_sig);
            end
        end
    endtask

    task automatic test_extremes();
        logic signed [15:0] vals [2];
        logic signed [15:0] exp_sig;
        vals[0] = 16'sh7FFF;
        vals[1] = 16'sh8000;
        apply_reset();
        log2_ratio = 3'd7;
        exp_sig = 16'sd0;
        for (int v = 0; v < 2; v++) begin
            for (int i = 0; i < 128; i++) begin
                drive(1'b1, vals[v]);
                n_checks++;
                if (ce_out !== (i == 127)) begin
                    n_fail++;
                    $display("FAIL extreme_ce v=%0d i=%0d: got %b", v, i, ce_out);
                end
                if (i == 127) exp_sig = vals[v];
                n_checks++;
                if (sig_out !== exp_sig) begin
                    n_fail++;
                    $display("FAIL extreme_sig v=%0d i=%0d: got %0d expected %0d",
                             v, i, sig_out, exp_sig);
                end
            end
        end
    endtask

    task automatic test_neg_round();
        logic signed [15:0] a [2];
        logic signed [15:0] b [2];
        logic signed [15:0] e [2];
        a[0] = -16'sd1; b[0] = -16'sd2; e[0] = -16'sd1;
        a[1] = -16'sd1; b[1] = 16'sd0;  e[1] = 16'sd0;
        apply_reset();
        log2_ratio = 3'd1;
        for (int t = 0; t < 2; t++) begin
            drive(1'b1, a[t]);
            n_checks++;
            if (ce_out !== 1'b0) begin
                n_fail++;
                $display("FAIL negrnd_ce_mid t=%0d: got %b expected 0", t, ce_out);
            end
            drive(1'b1, b[t]);
            n_checks++;
            if (ce_out !== 1'b1 || sig_out !== e[t]) begin
                n_fail++;
                $display("FAIL negrnd t=%0d: got ce=%b sig=%0d expected ce=1 sig=%0d",
                         t, ce_out, sig_out, e[t]);
            end
        end
    endtask

    task automatic test_gapped();
        logic signed [15:0] s [4];
        logic signed [15:0] exp_sig;
        logic               exp_ce;
        s[0] = 16'sd10; s[1] = 16'sd20; s[2] = 16'sd30; s[3] = 16'sd40;
        apply_reset();
        log2_ratio = 3'd1;
        exp_sig = 16'sd0;
        for (int i = 0; i < 4; i++) begin
            for (int g = 0; g < 3; g++) begin
                drive(g == 0, (g == 0) ? s[i] : 16'sd999);
                exp_ce = (g == 0) && (i % 2 == 1);
                if (exp_ce) exp_sig = (i == 1) ? 16'sd15 : 16'sd35;
                n_checks++;
                if (ce_out !== exp_ce || sig_out !== exp_sig) begin
                    n_fail++;
                    $display("FAIL gapped i=%0d g=%0d: got ce=%b sig=%0d expected ce=%b sig=%0d",
                             i, g, ce_out, sig_out, exp_ce, exp_sig);
                end
            end
        end
    endtask

    task automatic test_ratio_change();
        logic signed [15:0] s [7];
        logic signed [15:0] exp_sig;
        logic               exp_ce;
        s[0] = 16'sd4;  s[1] = 16'sd8; s[2] = 16'sd12; s[3] = 16'sd16;
        s[4] = 16'sd5;  s[5] = -16'sd7; s[6] = 16'sd3;
        apply_reset();
        log2_ratio = 3'd2;
        exp_sig = 16'sd0;
        for (int i = 0; i < 7; i++) begin
            if (i == 2) log2_ratio = 3'd0;
            drive(1'b1, s[i]);
            exp_ce = (i >= 3);
            if (i == 3) exp_sig = 16'sd10;
            else if (i > 3) exp_sig = s[i];
            n_checks++;
            if (ce_out !== exp_ce || sig_out !== exp_sig) begin
                n_fail++;
                $display("FAIL ratio_change i=%0d: got ce=%b sig=%0d expected ce=%b sig=%0d",
                         i, ce_out, sig_out, exp_ce, exp_sig);
            end
        end
    endtask

    task automatic test_reset_mid();
        apply_reset();
        log2_ratio = 3'd2;
        for (int i = 0; i < 3; i++) drive(1'b1, 16'sd100);
        rst = 1'b1;
        drive(1'b1, 16'sd100);
        n_checks++;
        if (ce_out !== 1'b0 || sig_out !== 16'sd0) begin
            n_fail++;
            $display("FAIL reset_mid_during: got ce=%b sig=%0d expected ce=0 sig=0",
                     ce_out, sig_out);
        end
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 16'sd8);
            n_checks++;
            if (ce_out !== (i == 3) || sig_out !== ((i == 3) ? 16'sd8 : 16'sd0)) begin
                n_fail++;
                $display("FAIL reset_mid_after i=%0d: got ce=%b sig=%0d", i, ce_out, sig_out);
            end
        end
    endtask

    initial begin
        test_reset();
        test_ramp();
        test_extremes();
        test_neg_round();
        test_gapped();
        test_ratio_change();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
